// File: rtl/alu_seq.sv
// Sequential ALU: add/sub/eq/lt in one step, iterative shift-add multiply and
// restoring divide over `width` steps, behind a start/busy/done handshake.
module alu_seq #(
  parameter int unsigned width = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [width-1:0]     a_i,
  input  logic [width-1:0]     b_i,
  input  logic [2:0]           fct_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*width-1:0]   s_o,
  output logic                 signal_o,
  output logic                 err_o
);

  localparam int unsigned CW = $clog2(width);
  localparam logic [CW-1:0] CNT_INIT = CW'(width - 1);

  localparam logic [2:0] FCT_ADD = 3'b000;
  localparam logic [2:0] FCT_SUB = 3'b001;
  localparam logic [2:0] FCT_MUL = 3'b010;
  localparam logic [2:0] FCT_EQ  = 3'b011;
  localparam logic [2:0] FCT_DIV = 3'b100;
  localparam logic [2:0] FCT_LT  = 3'b101;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [width-1:0]     a_q, a_d;
  logic [width-1:0]     b_q, b_d;
  logic [2:0]           fct_q, fct_d;
  logic [2*width-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*width-1:0]   s_q, s_d;
  logic                 signal_q, signal_d;
  logic                 err_q, err_d;

  logic [width:0]       add_res;
  logic [width:0]       sub_res;
  logic [width:0]       mul_sum;
  logic [2*width-1:0]   mul_next;
  logic [width:0]       div_shift;
  logic [width:0]       div_diff;
  logic                 div_ge;
  logic [2*width-1:0]   div_next;

  // acc holds {partial product, remaining multiplier bits} for mul and
  // {partial remainder, dividend/quotient bits} for div.
  always_comb begin
    add_res   = {1'b0, a_q} + {1'b0, b_q};
    sub_res   = {1'b0, a_q} - {1'b0, b_q};
    mul_sum   = {1'b0, acc_q[2*width-1:width]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next  = {mul_sum, acc_q[width-1:1]};
    div_shift = {acc_q[2*width-1:width], acc_q[width-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_next  = div_ge ? {div_diff[width-1:0], acc_q[width-2:0], 1'b1}
                       : {div_shift[width-1:0], acc_q[width-2:0], 1'b0};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    fct_d    = fct_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    signal_d = signal_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          fct_d   = fct_i;
          acc_d   = (fct_i == FCT_DIV) ? {{width{1'b0}}, a_i} : {{width{1'b0}}, b_i};
          cnt_d   = CNT_INIT;
          state_d = CALC;
        end
      end
      CALC: begin
        s_d      = '0;
        signal_d = 1'b0;
        err_d    = 1'b0;
        state_d  = DONE;
        case (fct_q)
          FCT_ADD: s_d = {{(width-1){1'b0}}, add_res};
          FCT_SUB: s_d = {{(width-1){1'b0}}, sub_res};
          FCT_EQ:  signal_d = (a_q == b_q);
          FCT_LT:  signal_d = (a_q < b_q);
          FCT_MUL: begin
            acc_d = mul_next;
            if (cnt_q == '0) begin
              s_d = mul_next;
            end else begin
              cnt_d    = cnt_q - CW'(1);
              s_d      = s_q;
              signal_d = signal_q;
              err_d    = err_q;
              state_d  = CALC;
            end
          end
          FCT_DIV: begin
            if (b_q == '0) begin
              s_d   = {a_q, {width{1'b1}}};
              err_d = 1'b1;
            end else begin
              acc_d = div_next;
              if (cnt_q == '0) begin
                s_d = div_next;
              end else begin
                cnt_d    = cnt_q - CW'(1);
                s_d      = s_q;
                signal_d = signal_q;
                err_d    = err_q;
                state_d  = CALC;
              end
            end
          end
          default: err_d = 1'b1;
        endcase
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      fct_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      s_q      <= '0;
      signal_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fct_q    <= fct_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      signal_q <= signal_d;
      err_q    <= err_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign s_o      = s_q;
  assign signal_o = signal_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq (width=8) against an arithmetic
// reference model; also covers handshake spacing and mid-operation reset.
module tb_alu_seq;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2:0]     fct = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] s;
  logic           sig;
  logic           err;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [2*W-1:0] last_s = '0;

  alu_seq #(.width(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .a_i(a), .b_i(b), .fct_i(fct),
    .busy_o(busy), .done_o(done), .s_o(s), .signal_o(sig), .err_o(err)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference: results straight from the arithmetic definition of each op.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [2:0] mf,
                       output logic [2*W-1:0] es, output logic esig, output logic eerr,
                       output int elat);
    int ia, ib;
    ia = int'(ma); ib = int'(mb);
    es = '0; esig = 1'b0; eerr = 1'b0; elat = 1;
    case (mf)
      3'd0: es = 16'(ia + ib);
      3'd1: es = 16'((ia - ib + 512) % 512);
      3'd2: begin es = 16'(ia * ib); elat = W; end
      3'd3: esig = (ia == ib);
      3'd4: begin
        if (ib == 0) begin es = 16'(ia * 256 + 255); eerr = 1'b1; end
        else begin es = 16'((ia % ib) * 256 + (ia / ib)); elat = W; end
      end
      3'd5: esig = (ia < ib);
      default: eerr = 1'b1;
    endcase
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin @(posedge clk); #1; n++; end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!done && lat < 20);
  endtask

  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic [2:0] of);
    logic [2*W-1:0] es;
    logic esig, eerr;
    int elat, lat;
    model(oa, ob, of, es, esig, eerr, elat);
    wait_idle();
    a = oa; b = ob; fct = of; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); fct = 3'($urandom);
    check("busy_cap", 32'(busy), 32'd1);
    check("hold_s", 32'(s), 32'(last_s));
    wait_done(lat);
    check("latency", 32'(lat), 32'(elat));
    check("s", 32'(s), 32'(es));
    check("signal", 32'(sig), 32'(esig));
    check("err", 32'(err), 32'(eerr));
    check("busy_done", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
    last_s = es;
    $display("op fct=%0d a=0x%02h b=0x%02h -> s=0x%04h sig=%0b err=%0b lat=%0d",
             of, oa, ob, s, sig, err, lat);
  endtask

  initial begin
    logic [W-1:0] x1, y1, x2, y2;
    int lat, t1, t2, nd;

    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_sig", 32'(sig), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'd200, 8'd100, 3'b000);
    run_op(8'd5, 8'd7, 3'b001);
    run_op(8'd5, 8'd7, 3'b101);
    run_op(8'h5A, 8'h5A, 3'b011);
    run_op(8'd255, 8'd255, 3'b010);
    run_op(8'd0, 8'h80, 3'b010);
    run_op(8'd100, 8'd7, 3'b100);
    run_op(8'h3C, 8'd0, 3'b100);
    run_op(8'd255, 8'd1, 3'b100);
    run_op(8'd3, 8'd200, 3'b100);
    run_op(8'd0, 8'd255, 3'b001);
    run_op(8'd9, 8'd9, 3'b101);
    run_op(8'd12, 8'd34, 3'b111);
    run_op(8'd12, 8'd34, 3'b110);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      run_op(ra, rb, 3'($urandom_range(0, 7)));
    end

    // start held high: back-to-back multiplies, operands disturbed during CALC
    x1 = W'($urandom_range(1, 255)); y1 = W'($urandom_range(1, 255));
    x2 = W'($urandom_range(1, 255)); y2 = W'($urandom_range(1, 255));
    wait_idle();
    a = x1; b = y1; fct = 3'b010; start = 1'b1;
    @(posedge clk); #1;
    a = x2; b = y2;
    wait_done(lat);
    t1 = cyc;
    check("hs_lat1", 32'(lat), 32'(W));
    check("hs_s1", 32'(s), 32'(16'(int'(x1) * int'(y1))));
    @(posedge clk); #1;
    check("hs_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("hs_recap", 32'(busy), 32'd1);
    start = 1'b0; a = W'($urandom); b = W'($urandom); fct = 3'($urandom);
    wait_done(lat);
    t2 = cyc;
    check("hs_gap", 32'(t2 - t1), 32'd10);
    check("hs_s2", 32'(s), 32'(16'(int'(x2) * int'(y2))));
    $display("handshake mul 0x%02h*0x%02h then 0x%02h*0x%02h -> s=0x%04h gap=%0d",
             x1, y1, x2, y2, s, t2 - t1);
    @(posedge clk); #1;
    last_s = 16'(int'(x2) * int'(y2));
    run_op(8'd12, 8'd34, 3'b111);
    run_op(8'd77, 8'd3, 3'b000);

    // asynchronous reset four cycles into a multiply
    wait_idle();
    a = 8'd255; b = 8'd255; fct = 3'b010; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_s", 32'(s), 32'd0);
    check("mid_rst_sig", 32'(sig), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("no_done_after_rst", 32'(nd), 32'd0);
    $display("reset mid-mul: outputs cleared, done pulses after release=%0d", nd);
    last_s = '0;
    run_op(8'd1, 8'd1, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Sequential, parametrised successor to the team's combinational 4-function ALU (add/sub/mul/equal).
- Adds unsigned iterative multiply (shift-add), unsigned restoring divide, less-than compare and a start/busy/done handshake.
- Results are registered and held.
- Sits between the calculator keypad/control FSM and the display path; one operation is in flight at a time.

Parameters:
- width, 8, operand width in bits (≥2); result bus is 2*width.

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- start_i  input  1  request; sampled only in IDLE
- a_i  input  width  operand A, unsigned
- b_i  input  width  operand B, unsigned
- fct_i  input  3  operation: 000 add, 001 sub, 010 mul, 011 eq, 100 div, 101 lt, 110/111 illegal
- busy_o  output  1  high while state ≠ IDLE
- done_o  output  1  one-cycle pulse; result valid
- s_o  output  2*width  numeric result
- signal_o  output  1  compare result (eq/lt)
- err_o  output  1  divide-by-zero or illegal fct_i

Behaviour:
- Clock and reset: one clock (clk_i); asynchronous active-low reset (rst_ni).
- Reset (rst_ni=0, any time, including mid-operation): state=IDLE; busy_o, done_o, s_o, signal_o, err_o and all internal operand/accumulator/counter registers = 0.
  - An in-flight operation is abandoned; no done_o pulse follows.
- FSM states: IDLE, CALC, DONE.
- IDLE: start_i=1 at edge k captures a_i, b_i and fct_i into internal registers and moves to CALC.
  - busy_o=1 from edge k onward.
  - Inputs are don't-care after capture.
- CALC, single-step ops (add, sub, eq, lt, illegal, div with b=0): result written at edge k+1, then DONE.
- CALC, mul and div (b≠0): width iterations on edges k+1..k+width; result written at edge k+width, then DONE.
  - Iteration counter is log2-sized and counts width-1 down to 0.
- DONE: done_o=1 for exactly this cycle; next edge → IDLE.
  - busy_o stays 1 in DONE, so start_i is never accepted in DONE.
- Latency (start edge to done_o high): 1 cycle for single-step ops, width cycles for mul/div.
- start_i while busy_o=1 is ignored and has no side effect.
- s_o, signal_o and err_o update only on the result edge, then hold until the next result edge. They are not cleared by accepting a new start.
- Each result write sets all three outputs; fields not produced by the operation are written 0.
- add: s_o = zero-extended (width+1)-bit a+b.
- sub: s_o = zero-extended (width+1)-bit (a−b) mod 2^(width+1); bit width is 1 iff a<b.
- mul: s_o = a*b, full 2*width bits, via LSB-first shift-add; no truncation.
- div: s_o = {remainder[width-1:0], quotient[width-1:0]}, restoring algorithm, one quotient bit per iteration.
- div by zero: single step; quotient = all ones, remainder = a, err_o=1.
- eq: signal_o = (a==b); s_o=0.
- lt: signal_o = (a<b) unsigned; s_o=0.
- illegal fct_i: single step; s_o=0, signal_o=0, err_o=1.
- err_o=0 for every legal non-fault result.
- No combinational path from any input to any output; all outputs are registered.

Test Plan (width=8):
- add: a=200, b=100, fct=000, start pulse → done_o exactly 1 cycle after start edge; s_o=0x012C, signal_o=0, err_o=0; busy_o high during CALC and DONE only.
- sub/lt: a=5, b=7, sub → s_o=0x01FE. Then lt with same operands → signal_o=1, s_o=0x0000. Then eq with a=b=0x5A → signal_o=1.
- mul: a=255, b=255 → done_o 8 cycles after start edge; s_o=0xFE01. Also a=0, b=0x80 → s_o=0x0000.
- div: a=100, b=7 → done after 8 cycles; s_o=0x020E (r=2, q=14). Then a=0x3C, b=0 → done after 1 cycle; s_o=0x3CFF, err_o=1.
- Handshake: hold start_i=1 continuously with mul ops → a new op is accepted every 10 cycles (capture, 8 CALC, DONE, re-accept in IDLE). Operand changes during CALC do not affect the result; fct=111 → err_o=1, s_o=0.
- Reset mid-operation: assert rst_ni=0 asynchronously 4 cycles into a mul → all outputs 0 immediately (before the next edge); no done_o after release. A subsequent add 1+1 gives s_o=0x0002.
